// File: rtl/memory_sdram_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_sdram_bus_bridge_pkg
//  Purpose  : Shared helpers for bus-to-SDRAM bridges (byte merge, widths)
//  Revision : 1.0 - initial release
// ============================================================================
package memory_sdram_bus_bridge_pkg;

  localparam int c_addr_w = 26;
  localparam int c_half_w = 16;

  // Per-byte merge of a halfword: mask bit 1 selects the high byte [15:8],
  // mask bit 0 the low byte [7:0]; unselected bytes keep the read-back data.
  function automatic logic [15:0] merge16(input logic [15:0] wdata16,
                                          input logic [15:0] rdata16,
                                          input logic [1:0]  mask2);
    merge16 = {mask2[1] ? wdata16[15:8] : rdata16[15:8],
               mask2[0] ? wdata16[7:0]  : rdata16[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_sdram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : memory_sdram_bus_bridge
//  Purpose  : Splits 32-bit masked word requests into 16-bit SDRAM
//             request/ack transactions, with read-modify-write for
//             partial-halfword writes (big-endian halves).
//  Revision : 1.0 - initial release
// ============================================================================
module memory_sdram_bus_bridge
  import memory_sdram_bus_bridge_pkg::*;
#(
  parameter bit RMW_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_request,
  output logic        bus_ack,
  input  logic        bus_write,
  input  logic [25:0] bus_address,
  input  logic [3:0]  bus_wmask,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        mem_request,
  input  logic        mem_ack,
  output logic        mem_write,
  output logic [25:0] mem_address,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAN    = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_ADVANCE = 3'd4
  } e_state;

  e_state      r_state;
  e_state      w_state_next;
  logic        r_half;
  logic        w_half_next;
  logic        w_mem_request_next;
  logic        w_mem_write_next;
  logic        w_bus_ack_next;
  logic [31:0] w_bus_rdata_next;
  logic        w_accept;
  logic        w_capture;

  // Operation latched at acceptance; bus inputs are free to change afterwards
  logic        r_write;
  logic [23:0] r_addr;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;
  logic [15:0] r_rbuf0;
  logic [15:0] r_rbuf1;

  logic [1:0]  w_mask_h;
  logic [15:0] w_wdata_h;
  logic [15:0] w_rbuf_h;
  logic        w_partial;
  logic        w_need_read;
  logic        w_need_write;
  logic [1:0]  w_merge_mask;
  logic        w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^bus_address[1:0];

  // Half 0 is the upper halfword at byte offset 0, half 1 the lower one
  assign w_mask_h     = r_half ? r_wmask[1:0]  : r_wmask[3:2];
  assign w_wdata_h    = r_half ? r_wdata[15:0] : r_wdata[31:16];
  assign w_rbuf_h     = r_half ? r_rbuf1       : r_rbuf0;
  assign w_partial    = (w_mask_h == 2'b01) || (w_mask_h == 2'b10);
  assign w_need_read  = !r_write || (RMW_ENABLE && w_partial);
  assign w_need_write = r_write && (w_mask_h != 2'b00);
  // Without RMW any touched half is written whole
  assign w_merge_mask = RMW_ENABLE ? w_mask_h : 2'b11;

  assign mem_wdata   = merge16(w_wdata_h, w_rbuf_h, w_merge_mask);
  assign mem_address = {r_addr, r_half, 1'b0};

  // Next-state and registered-output decode for the per-half sequencer
  always_comb begin
    w_state_next       = r_state;
    w_half_next        = r_half;
    w_mem_request_next = mem_request;
    w_mem_write_next   = mem_write;
    w_bus_ack_next     = 1'b0;
    w_bus_rdata_next   = bus_rdata;
    w_accept           = 1'b0;
    w_capture          = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A request still held during the ack cycle belongs to the finished op
        if (bus_request && !bus_ack) begin
          w_accept     = 1'b1;
          w_half_next  = 1'b0;
          w_state_next = S_PLAN;
        end
      end
      S_PLAN: begin
        if (w_need_read) begin
          w_state_next       = S_READ;
          w_mem_request_next = 1'b1;
          w_mem_write_next   = 1'b0;
        end else if (w_need_write) begin
          w_state_next       = S_WRITE;
          w_mem_request_next = 1'b1;
          w_mem_write_next   = 1'b1;
        end else begin
          w_state_next = S_ADVANCE;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          w_capture = 1'b1;
          if (w_need_write) begin
            w_state_next     = S_WRITE;
            w_mem_write_next = 1'b1;
          end else begin
            w_state_next       = S_ADVANCE;
            w_mem_request_next = 1'b0;
          end
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          w_state_next       = S_ADVANCE;
          w_mem_request_next = 1'b0;
          w_mem_write_next   = 1'b0;
        end
      end
      S_ADVANCE: begin
        if (!r_half) begin
          w_half_next  = 1'b1;
          w_state_next = S_PLAN;
        end else begin
          w_state_next   = S_IDLE;
          w_bus_ack_next = 1'b1;
          if (!r_write) begin
            w_bus_rdata_next = {r_rbuf0, r_rbuf1};
          end
        end
      end
      default: begin
        w_state_next       = S_IDLE;
        w_mem_request_next = 1'b0;
        w_mem_write_next   = 1'b0;
      end
    endcase
  end

  // Sequencer state and bus/memory handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_half      <= 1'b0;
      bus_ack     <= 1'b0;
      bus_rdata   <= 32'd0;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_half      <= w_half_next;
      bus_ack     <= w_bus_ack_next;
      bus_rdata   <= w_bus_rdata_next;
      mem_request <= w_mem_request_next;
      mem_write   <= w_mem_write_next;
    end
  end

  // Latch the accepted operation and capture read-back halfwords
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_addr  <= 24'd0;
      r_wmask <= 4'd0;
      r_wdata <= 32'd0;
      r_rbuf0 <= 16'd0;
      r_rbuf1 <= 16'd0;
    end else begin
      if (w_accept) begin
        r_write <= bus_write;
        r_addr  <= bus_address[25:2];
        r_wmask <= bus_wmask;
        r_wdata <= bus_wdata;
      end
      if (w_capture) begin
        if (r_half) begin
          r_rbuf1 <= mem_rdata;
        end else begin
          r_rbuf0 <= mem_rdata;
        end
      end
    end
  end

  // The controller must only acknowledge an outstanding command
  a_ack_in_cmd: assert property (@(posedge clk) disable iff (!reset_n)
                                 mem_ack |-> (r_state inside {S_READ, S_WRITE}))
    else $error("mem_ack received with no memory command outstanding");

endmodule
`default_nettype wire

// File: tb/tb_memory_sdram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_sdram_bus_bridge
//  Purpose  : Directed plus randomized bench with an SDRAM controller model
//             and a transaction-level expectation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_sdram_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bus_request;
  logic        bus_ack;
  logic        bus_write;
  logic [25:0] bus_address;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        mem_request;
  logic        mem_ack;
  logic        mem_write;
  logic [25:0] mem_address;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;

  memory_sdram_bus_bridge #(.RMW_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_request(bus_request), .bus_ack(bus_ack), .bus_write(bus_write),
    .bus_address(bus_address), .bus_wmask(bus_wmask), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .mem_request(mem_request), .mem_ack(mem_ack),
    .mem_write(mem_write), .mem_address(mem_address), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [25:0] addr;
    logic [15:0] data;
  } op_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [logic [25:0]];
  op_t         act_q[$];
  op_t         exp_q[$];
  int          ack_delay = 0;
  int          ack_total = 0;
  logic        req_seen = 1'b0;
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [25:0] a);
    if (mem.exists(a)) return mem[a];
    return a[16:1] ^ 16'hA5C3;
  endfunction

  // Expected SDRAM operations for one word request, half 0 first
  task automatic build_expect(input logic wr, input logic [25:0] addr, input logic [3:0] mask,
                              input logic [31:0] wdata, inout logic [31:0] rd);
    logic [25:0] a;
    logic [1:0]  m;
    logic [15:0] wh, old, nv;
    for (int h = 0; h < 2; h++) begin
      a   = {addr[25:2], h[0], 1'b0};
      m   = (h == 0) ? mask[3:2] : mask[1:0];
      wh  = (h == 0) ? wdata[31:16] : wdata[15:0];
      old = rd_mem(a);
      if (!wr) begin
        exp_q.push_back(op_t'{1'b0, a, old});
        if (h == 0) rd[31:16] = old; else rd[15:0] = old;
      end else if (m == 2'b11) begin
        exp_q.push_back(op_t'{1'b1, a, wh});
      end else if (m != 2'b00) begin
        nv = old;
        if (m[1]) nv[15:8] = wh[15:8]; else nv[7:0] = wh[7:0];
        exp_q.push_back(op_t'{1'b0, a, old});
        exp_q.push_back(op_t'{1'b1, a, nv});
      end
    end
  endtask

  task automatic compare_ops(input string tag);
    check({tag, "_opcount"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({tag, "_op"}, 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_ack(output logic got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (bus_ack === 1'b1) got = 1'b1;
    end
  endtask

  // SDRAM controller model: acks after ack_delay cycles, aborts if request drops
  initial begin
    logic [25:0] a;
    logic        w, ok, last_wr;
    logic [15:0] d;
    mem_ack   = 1'b0;
    mem_rdata = 16'd0;
    last_wr   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (last_wr) check("req_low_after_wr_ack", 64'(mem_request), 64'd0);
        else         check("req_after_rd_ack", 64'(mem_request && !mem_write), 64'd0);
      end
      if (mem_request === 1'b1) begin
        a  = mem_address;
        w  = mem_write;
        d  = mem_wdata;
        ok = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk); #1;
          if (mem_request !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          check("cmd_stable", {37'd0, mem_write, mem_address}, {37'd0, w, a});
          if (w) begin
            mem[a]    = d;
            mem_rdata = 16'($urandom);
          end else begin
            mem_rdata = rd_mem(a);
          end
          act_q.push_back(op_t'{w, a, w ? d : mem_rdata});
          last_wr = w;
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Bus ack and memory request monitors
  initial forever begin
    @(negedge clk);
    if (bus_ack === 1'b1) ack_total++;
    if (mem_request === 1'b1) req_seen = 1'b1;
  end

  task automatic do_txn(input logic wr, input logic [25:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input int delay, input int exp_lat);
    logic [31:0] exp_rd;
    logic        got;
    int          n, acks0;
    exp_q.delete();
    act_q.delete();
    exp_rd = 32'd0;
    build_expect(wr, addr, mask, wdata, exp_rd);
    if (wr) exp_rd = last_rd;
    ack_delay = delay;
    acks0     = ack_total;
    req_seen  = 1'b0;
    @(negedge clk);
    bus_write = wr; bus_address = addr; bus_wmask = mask; bus_wdata = wdata;
    bus_request = 1'b1;
    @(posedge clk); #1;
    // Operation is accepted; scramble bus inputs while still holding request
    bus_write = 1'($urandom); bus_address = 26'($urandom);
    bus_wmask = 4'($urandom); bus_wdata = $urandom;
    wait_ack(got, n);
    check("ack_seen", 64'(got), 64'd1);
    check("rdata", 64'(bus_rdata), 64'(exp_rd));
    if (exp_lat > 0) check("ack_latency", 64'(n + 1), 64'(exp_lat));
    last_rd = exp_rd;
    bus_request = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("one_ack", 64'(ack_total - acks0), 64'd1);
    compare_ops("txn");
  endtask

  initial begin
    logic [31:0] rd1, rd2;
    logic        got;
    int          n, acks0;
    logic        wr;
    logic [25:0] addr;
    logic [3:0]  mask;
    reset_n = 1'b0;
    bus_request = 1'b0; bus_write = 1'b0; bus_address = 26'd0;
    bus_wmask = 4'd0; bus_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_ack", 64'(bus_ack), 64'd0);
    check("rst_mem_request", 64'(mem_request), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_bus_rdata", 64'(bus_rdata), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // Two-half read
    mem[26'h104] = 16'hAABB;
    mem[26'h106] = 16'hCCDD;
    do_txn(1'b0, 26'h104, 4'h0, 32'd0, 0, 0);
    check("read_104", 64'(bus_rdata), 64'hAABBCCDD);

    // Full-word write
    do_txn(1'b1, 26'h200, 4'b1111, 32'h11223344, 1, 0);
    check("wr_full_200", 64'(mem[26'h200]), 64'h1122);
    check("wr_full_202", 64'(mem[26'h202]), 64'h3344);

    // Single-byte writes via read-modify-write
    mem[26'h200] = 16'hBEEF;
    mem[26'h202] = 16'hCAFE;
    do_txn(1'b1, 26'h200, 4'b0100, 32'h11223344, 0, 0);
    check("rmw_hi_200", 64'(mem[26'h200]), 64'hBE22);
    check("rmw_hi_202", 64'(mem[26'h202]), 64'hCAFE);
    mem[26'h202] = 16'hBEEF;
    do_txn(1'b1, 26'h200, 4'b0010, 32'h11223344, 2, 0);
    check("rmw_lo_202", 64'(mem[26'h202]), 64'h33EF);

    // Empty mask: no SDRAM traffic, fixed latency
    do_txn(1'b1, 26'h300, 4'b0000, 32'hDEADBEEF, 0, 5);
    check("nomask_no_req", 64'(req_seen), 64'd0);

    // Request held across bus_ack becomes exactly one further read
    exp_q.delete(); act_q.delete();
    rd1 = 32'd0; rd2 = 32'd0;
    build_expect(1'b0, 26'h500, 4'h0, 32'd0, rd1);
    build_expect(1'b0, 26'h508, 4'h0, 32'd0, rd2);
    acks0 = ack_total;
    ack_delay = 0;
    @(negedge clk);
    bus_write = 1'b0; bus_address = 26'h500; bus_request = 1'b1;
    wait_ack(got, n);
    check("held_ack1", 64'(got), 64'd1);
    check("held_rd1", 64'(bus_rdata), 64'(rd1));
    bus_address = 26'h508;
    ack_delay = 3;
    wait_ack(got, n);
    check("held_ack2", 64'(got), 64'd1);
    check("held_rd2", 64'(bus_rdata), 64'(rd2));
    bus_request = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("held_ack_count", 64'(ack_total - acks0), 64'd2);
    compare_ops("held");
    last_rd = rd2;

    // Reset while a read is outstanding
    act_q.delete();
    ack_delay = 50;
    acks0 = ack_total;
    @(negedge clk);
    bus_write = 1'b0; bus_address = 26'h400; bus_request = 1'b1;
    n = 0;
    while (mem_request !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_req_up", 64'(mem_request), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_req", 64'(mem_request), 64'd0);
    check("rst_async_ack", 64'(bus_ack), 64'd0);
    check("rst_async_rdata", 64'(bus_rdata), 64'd0);
    last_rd = 32'd0;
    bus_request = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    ack_delay = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_ack", 64'(ack_total - acks0), 64'd0);
    check("rst_no_ops", 64'(act_q.size()), 64'd0);
    do_txn(1'b0, 26'h400, 4'h0, 32'd0, 1, 0);

    // Randomized traffic over a small window plus the top word
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = (i == 7) ? 26'h3FFFFFC : 26'($urandom_range(0, 31)) << 2;
      mask = 4'($urandom);
      do_txn(wr, addr, mask, $urandom, $urandom_range(0, 3), (wr && mask == 4'd0) ? 5 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
